// File: rtl/nn_pkg.sv
// Shared Q8.8 constants, sequencer state encoding and saturation helpers.
package nn_pkg;

    localparam int unsigned DW     = 16;
    localparam int unsigned FRAC   = 8;
    localparam int unsigned ACC_W  = 40;
    localparam int unsigned PROD_W = 2 * DW;

    localparam logic signed [DW-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [DW-1:0] Q_MIN = 16'sh8000;

    localparam logic signed [ACC_W-1:0] ACC_Q_MAX = ACC_W'(Q_MAX);
    localparam logic signed [ACC_W-1:0] ACC_Q_MIN = ACC_W'(Q_MIN);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        REDUCE = 3'd2,
        ACT    = 3'd3,
        HOLD   = 3'd4
    } nseq_state_t;

    // Clamp a wide signed value into the Q8.8 range.
    function automatic logic [DW-1:0] sat_to_q8(input logic signed [ACC_W-1:0] v);
        if (v > ACC_Q_MAX) begin
            return Q_MAX;
        end else if (v < ACC_Q_MIN) begin
            return Q_MIN;
        end else begin
            return v[DW-1:0];
        end
    endfunction

    function automatic logic q8_out_of_range(input logic signed [ACC_W-1:0] v);
        return (v > ACC_Q_MAX) || (v < ACC_Q_MIN);
    endfunction

endpackage

// File: rtl/neuron_sequencer_activation.sv
// Combinational activation unit: relu(sat(weight_product + b)) in Q8.8.
module activation
    import nn_pkg::*;
(
    input  logic [DW-1:0] weight_product,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] activation
);

    logic signed [DW:0]    sum_c;
    logic        [DW-1:0]  sat_c;

    assign sum_c = $signed({weight_product[DW-1], weight_product}) + $signed({b[DW-1], b});
    assign sat_c = sat_to_q8(ACC_W'(sum_c));
    assign activation = sat_c[DW-1] ? '0 : sat_c;

endmodule

// File: rtl/neuron_sequencer.sv
// One-neuron dot-product sequencer feeding the shared activation unit.
// Optional sat_flag output enabled by defining NEURON_SEQ_SAT_FLAG_EN.
module neuron_sequencer
    import nn_pkg::*;
#(
    parameter int unsigned N_INPUTS = 4
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] bias,
    output logic          busy,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [DW-1:0] x_data,
    input  logic [DW-1:0] w_data,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef NEURON_SEQ_SAT_FLAG_EN
    output logic          sat_flag,
`endif
    output logic [DW-1:0] out_data
);

    localparam int unsigned CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

    nseq_state_t state_q, state_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]           bias_q, bias_d;
    logic [DW-1:0]           wp_q, wp_d;
    logic [DW-1:0]           out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    x_ready_q, x_ready_d;
`ifdef NEURON_SEQ_SAT_FLAG_EN
    logic                    sat_q, sat_d;
`endif

    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  shifted_c;
    logic [DW-1:0]            act_c;

    assign prod_c    = $signed(x_data) * $signed(w_data);
    assign shifted_c = acc_q >>> FRAC;

    activation u_activation (
        .weight_product (wp_q),
        .b              (bias_q),
        .activation     (act_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            bias_q      <= '0;
            wp_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            x_ready_q   <= 1'b0;
`ifdef NEURON_SEQ_SAT_FLAG_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bias_q      <= bias_d;
            wp_q        <= wp_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            x_ready_q   <= x_ready_d;
`ifdef NEURON_SEQ_SAT_FLAG_EN
            sat_q       <= sat_d;
`endif
        end
    end

    // Next-state and datapath updates; busy/x_ready are decoded from the next state.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bias_d      = bias_q;
        wp_d        = wp_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef NEURON_SEQ_SAT_FLAG_EN
        sat_d       = sat_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    bias_d  = bias;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (x_valid && x_ready_q) begin
                    acc_d = acc_q + ACC_W'(prod_c);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = REDUCE;
                    end
                end
            end
            REDUCE: begin
                wp_d    = sat_to_q8(shifted_c);
`ifdef NEURON_SEQ_SAT_FLAG_EN
                sat_d   = q8_out_of_range(shifted_c);
`endif
                state_d = ACT;
            end
            ACT: begin
                out_data_d  = act_c;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
`ifdef NEURON_SEQ_SAT_FLAG_EN
                    sat_d       = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d    = (state_d != IDLE);
        x_ready_d = (state_d == ACCUM);
    end

    assign busy      = busy_q;
    assign x_ready   = x_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef NEURON_SEQ_SAT_FLAG_EN
    assign sat_flag  = sat_q;
`endif

endmodule
